sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_arbiter_if.sv | 42 ++++
 rtl/sram_arb_pick.sv | 20 ++
 rtl/sram_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding and requester indices.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_CPU = 1'b0;
  localparam req_idx_t REQ_VID = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-port bundle; master is the arbiter side, slave is the requesters/SRAM side.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 19
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              vid_req;
  logic              vid_we;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_wdata;
  logic              vid_ack;
  logic [7:0]        vid_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_indata;
  logic              mem_load;
  logic              mem_store;
  logic [7:0]        mem_outdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_we, vid_addr, vid_wdata,
    input  mem_outdata,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    output mem_address, mem_indata, mem_load, mem_store
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_we, vid_addr, vid_wdata,
    output mem_outdata,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    input  mem_address, mem_indata, mem_load, mem_store
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Two-way winner select; on a tie the requester not granted last wins.
module sram_arb_pick
  import sram_pkg::*;
(
  input  logic     cpu_req_i,
  input  logic     vid_req_i,
  input  req_idx_t last_grant_i,
  output req_idx_t winner_o
);

  always_comb begin
    winner_o = REQ_CPU;
    if (cpu_req_i && vid_req_i) begin
      winner_o = (last_grant_i == REQ_VID) ? REQ_CPU : REQ_VID;
    end else if (vid_req_i) begin
      winner_o = REQ_VID;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter (IDLE/ACCESS/DONE). Define SRAM_ARBITER_FAIR_EN for
// round-robin tie-break; default is fixed priority with vid winning.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_W        = 19
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           prog,
  sram_arbiter_if.master bus
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  req_idx_t          win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              load_q;
  logic              store_q;
  logic              cpu_ack_q;
  logic              vid_ack_q;
  logic [7:0]        cpu_rdata_q;
  logic [7:0]        vid_rdata_q;

  req_idx_t          last_grant;
  req_idx_t          pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

`ifdef SRAM_ARBITER_FAIR_EN
  req_idx_t last_q;
  assign last_grant = last_q;
`else
  // Presenting "cpu granted last" permanently makes every tie resolve to vid.
  assign last_grant = REQ_CPU;
`endif

  sram_arb_pick u_pick (
    .cpu_req_i    (bus.cpu_req),
    .vid_req_i    (bus.vid_req),
    .last_grant_i (last_grant),
    .winner_o     (pick)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (pick == REQ_VID) begin
      sel_we    = bus.vid_we;
      sel_addr  = bus.vid_addr;
      sel_wdata = bus.vid_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_q       <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
`ifdef SRAM_ARBITER_FAIR_EN
      last_q      <= REQ_VID;
`endif
    end else begin
      cpu_ack_q <= 1'b0;
      vid_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!prog && (bus.cpu_req || bus.vid_req)) begin
            win_q   <= pick;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            load_q  <= ~sel_we;
            store_q <= sel_we;
            cnt_q   <= '0;
            state_q <= ST_ACCESS;
`ifdef SRAM_ARBITER_FAIR_EN
            last_q  <= pick;
`endif
          end
        end
        ST_ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            load_q  <= 1'b0;
            store_q <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (win_q == REQ_VID) begin
            vid_ack_q <= 1'b1;
            if (!we_q) vid_rdata_q <= bus.mem_outdata;
          end else begin
            cpu_ack_q <= 1'b1;
            if (!we_q) cpu_rdata_q <= bus.mem_outdata;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_indata  = wdata_q;
  assign bus.mem_load    = load_q;
  assign bus.mem_store   = store_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.vid_ack     = vid_ack_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.vid_rdata   = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with default ACCESS_CYCLES=2 and a combinational SRAM model.
module tb_sram_arbiter;

  logic clock;
  logic reset;
  logic prog;

  int unsigned checks;
  int unsigned errors;

  sram_arbiter_if #(.ADDR_W(19)) bus ();

  sram_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(19)) dut (
    .clock (clock),
    .reset (reset),
    .prog  (prog),
    .bus   (bus)
  );

  // SRAM model: 0x00123 holds 0xA5, every other byte holds its low address byte.
  assign bus.mem_outdata = (bus.mem_address == 19'h00123) ? 8'hA5 : bus.mem_address[7:0];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp_vid [4];
    logic [7:0] exp_cpu_rd;
    logic [7:0] exp_vid_rd;
    checks = 0;
    errors = 0;
`ifdef SRAM_ARBITER_FAIR_EN
    exp_vid = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_cpu_rd = 8'h11;
`else
    exp_vid = '{1'b1, 1'b1, 1'b1, 1'b1};
    exp_cpu_rd = 8'hA5;
`endif
    exp_vid_rd = 8'h22;

    reset = 1'b1;
    prog  = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_we = 1'b0; bus.vid_addr = '0; bus.vid_wdata = '0;
    #2;
    chk("rst_load",  32'(bus.mem_load),  32'h0);
    chk("rst_store", 32'(bus.mem_store), 32'h0);
    chk("rst_addr",  32'(bus.mem_address), 32'h0);
    chk("rst_acks",  32'({bus.cpu_ack, bus.vid_ack}), 32'h0);
    chk("rst_rdata", 32'({bus.cpu_rdata, bus.vid_rdata}), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h00123;
    step();
    chk("rd_grant_load", 32'(bus.mem_load), 32'h1);
    chk("rd_grant_store", 32'(bus.mem_store), 32'h0);
    chk("rd_grant_addr", 32'(bus.mem_address), 32'h00123);
    step();
    chk("rd_hold_load", 32'(bus.mem_load), 32'h1);
    chk("rd_hold_ack", 32'(bus.cpu_ack), 32'h0);
    step();
    chk("rd_drop_load", 32'(bus.mem_load), 32'h0);
    chk("rd_early_ack", 32'(bus.cpu_ack), 32'h0);
    step();
    chk("rd_ack", 32'(bus.cpu_ack), 32'h1);
    chk("rd_vid_ack", 32'(bus.vid_ack), 32'h0);
    chk("rd_data", 32'(bus.cpu_rdata), 32'hA5);
    bus.cpu_req = 1'b0;
    step();
    chk("rd_ack_pulse", 32'(bus.cpu_ack), 32'h0);
    chk("rd_data_hold", 32'(bus.cpu_rdata), 32'hA5);

    // Single vid write at top of address range
    bus.vid_req = 1'b1; bus.vid_we = 1'b1; bus.vid_addr = 19'h7FFFF; bus.vid_wdata = 8'h3C;
    step();
    chk("wr_grant", 32'({bus.mem_store, bus.mem_load}), 32'h2);
    chk("wr_addr", 32'(bus.mem_address), 32'h7FFFF);
    chk("wr_data", 32'(bus.mem_indata), 32'h3C);
    step();
    chk("wr_hold", 32'({bus.mem_store, bus.mem_load}), 32'h2);
    step();
    chk("wr_drop", 32'({bus.mem_store, bus.mem_load}), 32'h0);
    step();
    chk("wr_ack", 32'({bus.vid_ack, bus.cpu_ack}), 32'h2);
    chk("wr_load_low", 32'(bus.mem_load), 32'h0);
    chk("wr_cpu_rdata_kept", 32'(bus.cpu_rdata), 32'hA5);
    chk("wr_vid_rdata_kept", 32'(bus.vid_rdata), 32'h00);
    bus.vid_req = 1'b0; bus.vid_we = 1'b0;
    step();
    chk("wr_ack_pulse", 32'(bus.vid_ack), 32'h0);

    // Simultaneous reads held over four accesses
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h00011;
    bus.vid_req = 1'b1; bus.vid_addr = 19'h00022;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("arb_addr%0d", i), 32'(bus.mem_address),
          exp_vid[i] ? 32'h00022 : 32'h00011);
      chk($sformatf("arb_load%0d", i), 32'(bus.mem_load), 32'h1);
      step();
      step();
      step();
      chk($sformatf("arb_ack%0d", i), 32'({bus.vid_ack, bus.cpu_ack}),
          exp_vid[i] ? 32'h2 : 32'h1);
    end
    bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
    chk("arb_vid_rdata", 32'(bus.vid_rdata), 32'(exp_vid_rd));
    chk("arb_cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rd));
    step();
    chk("arb_idle_load", 32'(bus.mem_load), 32'h0);

    // prog rises during ACCESS while cpu keeps requesting
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h00044;
    step();
    chk("prog_grant", 32'(bus.mem_load), 32'h1);
    prog = 1'b1;
    step();
    step();
    step();
    chk("prog_ack", 32'(bus.cpu_ack), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("prog_block%0d", i),
          32'({bus.mem_load, bus.mem_store, bus.cpu_ack}), 32'h0);
    end
    prog = 1'b0;
    step();
    chk("prog_regrant_load", 32'(bus.mem_load), 32'h1);
    chk("prog_regrant_addr", 32'(bus.mem_address), 32'h00044);
    step();
    step();
    step();
    chk("prog_regrant_ack", 32'(bus.cpu_ack), 32'h1);
    chk("prog_regrant_data", 32'(bus.cpu_rdata), 32'h44);
    bus.cpu_req = 1'b0;
    step();

    // Reset pulsed mid-ACCESS
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h00055;
    step();
    chk("rst2_grant", 32'(bus.mem_load), 32'h1);
    #2;
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    chk("rst2_load", 32'({bus.mem_load, bus.mem_store}), 32'h0);
    chk("rst2_addr", 32'(bus.mem_address), 32'h0);
    chk("rst2_rdata", 32'({bus.cpu_rdata, bus.vid_rdata}), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst2_noack%0d", i),
          32'({bus.cpu_ack, bus.vid_ack, bus.mem_load}), 32'h0);
    end
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h00066;
    step();
    chk("rst2_restart_load", 32'(bus.mem_load), 32'h1);
    step();
    step();
    step();
    chk("rst2_restart_ack", 32'(bus.cpu_ack), 32'h1);
    chk("rst2_restart_data", 32'(bus.cpu_rdata), 32'h66);
    bus.cpu_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
